operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side initiator for the 2-read/1-write integer register file: drives the two read addresses and captures the returned operands.
- Tracks in-flight destination registers with a scoreboard and stalls decode on RAW/WAW hazards.
- Forwards same-cycle writeback data around the register file, whose write lands at the next clock edge.
- Sits between decode and execute as a single-entry valid/ready pipeline stage.

Parameters:
TAG_W, 32, width of the opaque tag (normally the PC) carried alongside each instruction.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  decode presents an instruction.
in_ready  output  1  stage accepts the instruction this cycle.
in_rs1  input  5  source register 1 index.
in_rs2  input  5  source register 2 index.
in_rd  input  5  destination register index.
in_rd_we  input  1  instruction writes in_rd.
in_tag  input  TAG_W  passthrough tag.
rf_r1  output  5  register file read address 1.
rf_r2  output  5  register file read address 2.
rf_out_r1  input  32  register file combinational read data 1.
rf_out_r2  input  32  register file combinational read data 2.
wb_valid  input  1  writeback this cycle; the same signal drives the register file write enable.
wb_rd  input  5  writeback register index.
wb_data  input  32  writeback data.
out_valid  output  1  operands valid to execute.
out_ready  input  1  execute accepts.
out_op1  output  32  operand 1.
out_op2  output  32  operand 2.
out_rd  output  5  destination index.
out_rd_we  output  1  destination write enable.
out_tag  output  TAG_W  passthrough tag.
stall_count  output  32  count of hazard-stall cycles.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - Clears out_valid, the busy[31:1] scoreboard and stall_count.
  - Clears out_op1, out_op2, out_rd, out_rd_we and out_tag to 0.
  - Any accepted or in-flight instruction is discarded; wb_valid during reset is ignored.
- Read addressing:
  - rf_r1 = in_rs1 and rf_r2 = in_rs2, combinational and unconditional.
  - Operands are sampled from rf_out_r1/r2 in the accept cycle.
- x0 handling:
  - Register 0 is never busy and is never forwarded; an operand read from x0 is always 0.
  - in_rd_we with in_rd==0 does not touch the scoreboard. wb_rd==0 is ignored.
- wb_hit(r) = wb_valid && wb_rd==r && r!=0.
- Hazard:
  - hz = (busy[rs1] && !wb_hit(rs1)) || (busy[rs2] && !wb_hit(rs2)) || (in_rd_we && busy[rd] && !wb_hit(rd)), with each term evaluated only for a nonzero index.
- Handshake:
  - in_ready = !hz && (!out_valid || out_ready), combinational.
  - Accept = in_valid && in_ready.
  - Output hold: out_* stays stable while out_valid && !out_ready.
- Accept cycle:
  - Register out_op1 = wb_hit(rs1) ? wb_data : (rs1==0 ? 0 : rf_out_r1); same rule for op2 with rs2.
  - Register rd, rd_we and tag; set out_valid at the next edge.
  - Latency is 1 cycle from accept to out_valid.
- No accept and out_ready: out_valid clears.
- Scoreboard update, per posedge:
  - wb_valid clears busy[wb_rd].
  - Accept with in_rd_we && in_rd!=0 sets busy[in_rd].
  - The set is applied after the clear, so a simultaneous clear and set of the same index leaves it busy.
  - Writeback to a non-busy register is legal and a no-op on the scoreboard.
- stall_count:
  - Increments by 1 on each cycle with in_valid && hz; wraps 0xFFFFFFFF -> 0.
  - Does not count backpressure-only stalls (out_valid && !out_ready && !hz).
- Full throughput: back-to-back independent instructions with out_ready=1 accept every cycle.
- Performance limitation: a dependent instruction stalls until its producer's writeback cycle and issues in that cycle via forwarding. There is no execute-to-fetch bypass.

Test Plan:
- After reset, an instruction with rs1=0, rs2=0 and in_valid held -> accepted in cycle 1; next cycle out_valid=1, out_op1=0, out_op2=0, stall_count=0.
- Register file preloaded x5=0x11, x6=0x22; issue rs1=5, rs2=6, rd=7, we=1 -> out_op1=0x11, out_op2=0x22, busy[7]=1.
- Issue a producer with rd=7, then a consumer with rs1=7; wb of x7=0xABCD comes 3 cycles later -> in_ready=0 for 3 cycles, stall_count=3, consumer accepted in the wb cycle with out_op1=0xABCD.
- Producer rd=9 in flight, next instruction rd=9 (WAW) -> stalls until wb_rd=9; accepted in that cycle; busy[9] stays 1 afterwards.
- out_ready=0 for 4 cycles with out_valid=1 -> out_* stable, in_ready=0, stall_count unchanged; out_ready=1 -> next instruction accepted the same cycle.
- rst asserted while busy[3]=1 and out_valid=1 -> after one edge out_valid=0, busy all 0, an instruction reading x3 accepted immediately; wb_valid with wb_rd=0 has no effect.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with scoreboard hazard stall and writeback forwarding
module operand_fetch #(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic [TAG_W-1:0] in_tag,
  output logic [4:0]       rf_r1,
  output logic [4:0]       rf_r2,
  input  logic [31:0]      rf_out_r1,
  input  logic [31:0]      rf_out_r2,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_op1,
  output logic [31:0]      out_op2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      stall_count
);
  logic [31:0] busy, busy_nx;
  logic wh1, wh2, whd, hz, acc;
  assign rf_r1 = in_rs1;
  assign rf_r2 = in_rs2;
  // hazard detection, handshake and next scoreboard (clear before set so a re-issue stays busy)
  always_comb begin
    wh1 = wb_valid && wb_rd == in_rs1 && in_rs1 != 5'd0;
    wh2 = wb_valid && wb_rd == in_rs2 && in_rs2 != 5'd0;
    whd = wb_valid && wb_rd == in_rd && in_rd != 5'd0;
    hz = (in_rs1 != 5'd0 && busy[in_rs1] && !wh1) ||
         (in_rs2 != 5'd0 && busy[in_rs2] && !wh2) ||
         (in_rd_we && in_rd != 5'd0 && busy[in_rd] && !whd);
    in_ready = !hz && (!out_valid || out_ready);
    acc = in_valid && in_ready;
    busy_nx = busy;
    if (wb_valid) busy_nx[wb_rd] = 1'b0;
    if (acc && in_rd_we) busy_nx[in_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end
  // pipeline register, scoreboard and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_tag     <= '0;
      busy        <= '0;
      stall_count <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_op1   <= wh1 ? wb_data : (in_rs1 == 5'd0 ? 32'd0 : rf_out_r1);
        out_op2   <= wh2 ? wb_data : (in_rs2 == 5'd0 ? 32'd0 : rf_out_r2);
        out_rd    <= in_rd;
        out_rd_we <= in_rd_we;
        out_tag   <= in_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hz) stall_count <= stall_count + 32'd1;
      busy <= busy_nx;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: vector table plus hand sequences, outputs checked against a queue of expected results
module tb_operand_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_rd_we = 1'b0;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, rf_r1, rf_r2, wb_rd = '0, out_rd;
  logic [31:0] in_tag = '0, rf_out_r1, rf_out_r2, wb_data = '0, out_op1, out_op2, out_tag, stall_count;
  logic wb_valid = 1'b0, out_valid, out_ready = 1'b1, out_rd_we;
  logic [31:0] rf [32];
  int pass_n = 0, total_n = 0;
  logic a;

  typedef struct packed {
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] tag;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] e1, e2;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
  } vec_t;
  vec_t vecs[8];

  operand_fetch #(.TAG_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out_r1(rf_out_r1), .rf_out_r2(rf_out_r2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_tag(out_tag), .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  assign rf_out_r1 = rf[rf_r1];
  assign rf_out_r2 = rf[rf_r2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one cycle: drive at negedge, check handshakes, clock, then commit the writeback into the rf model
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic we, input logic [31:0] tag, input logic [31:0] e1, input logic [31:0] e2,
                      input logic wv, input logic [4:0] wrd, input logic [31:0] wd, input logic ordy,
                      output logic acc);
    exp_t e;
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_tag = tag;
    wb_valid = wv; wb_rd = wrd; wb_data = wd; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("out_without_expected", 128'(q.size()), 128'(1));
      else begin
        e = q.pop_front();
        chk($sformatf("out_tag%0h", e.tag), 128'({out_op1, out_op2, out_rd, out_rd_we, out_tag}), 128'(e));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e.op1 = e1; e.op2 = e2; e.rd = rd; e.we = we; e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
    rf[0] = 32'hDEAD_BEEF;
    rf[5] = 32'h11;
    rf[6] = 32'h22;
    vecs[0] = '{5'd1,  5'd2,  5'd0, 1'b0, 32'hA000_0001, 32'hA000_0002, 1'b0, 5'd0, 32'h0};
    vecs[1] = '{5'd31, 5'd0,  5'd0, 1'b1, 32'hA000_001F, 32'h0,         1'b0, 5'd0, 32'h0};
    vecs[2] = '{5'd0,  5'd31, 5'd0, 1'b1, 32'h0,         32'hA000_001F, 1'b0, 5'd0, 32'h0};
    vecs[3] = '{5'd5,  5'd6,  5'd0, 1'b0, 32'h11,        32'h22,        1'b0, 5'd0, 32'h0};
    vecs[4] = '{5'd6,  5'd5,  5'd0, 1'b0, 32'h22,        32'h11,        1'b0, 5'd0, 32'h0};
    vecs[5] = '{5'd4,  5'd4,  5'd0, 1'b0, 32'hA000_0004, 32'hA000_0004, 1'b0, 5'd0, 32'h0};
    vecs[6] = '{5'd4,  5'd2,  5'd0, 1'b0, 32'h4444,      32'hA000_0002, 1'b1, 5'd4, 32'h4444};
    vecs[7] = '{5'd2,  5'd4,  5'd0, 1'b0, 32'hA000_0002, 32'h4444,      1'b0, 5'd0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_stall_count", 128'(stall_count), 128'(0));
    chk("rst_out_regs", 128'({out_op1, out_op2, out_rd, out_rd_we, out_tag}), 128'(0));

    step(1, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0, 1, a);
    chk("x0_accept", 128'(a), 128'(1));

    for (int i = 0; i < 8; i++) begin
      step(1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we, 32'h100 + 32'(i), vecs[i].e1, vecs[i].e2,
           vecs[i].wv, vecs[i].wrd, vecs[i].wd, 1, a);
      chk($sformatf("vec%0d_accept", i), 128'(a), 128'(1));
    end
    chk("vec_stall_count", 128'(stall_count), 128'(0));

    step(1, 5, 6, 7, 1, 32'h200, 32'h11, 32'h22, 0, 0, 0, 1, a);
    chk("producer7_accept", 128'(a), 128'(1));
    for (int k = 0; k < 3; k++) begin
      step(1, 7, 0, 8, 0, 32'h201, 32'hABCD, 0, 0, 0, 0, 1, a);
      chk($sformatf("raw_stall%0d", k), 128'(a), 128'(0));
    end
    step(1, 7, 0, 8, 0, 32'h201, 32'hABCD, 0, 1, 7, 32'hABCD, 1, a);
    chk("raw_fwd_accept", 128'(a), 128'(1));
    chk("raw_stall_count", 128'(stall_count), 128'(3));

    step(1, 0, 0, 9, 1, 32'h300, 0, 0, 0, 0, 0, 1, a);
    chk("producer9_accept", 128'(a), 128'(1));
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 9, 1, 32'h301, 0, 0, 0, 0, 0, 1, a);
      chk($sformatf("waw_stall%0d", k), 128'(a), 128'(0));
    end
    step(1, 0, 0, 9, 1, 32'h301, 0, 0, 1, 9, 32'h99, 1, a);
    chk("waw_accept_on_wb", 128'(a), 128'(1));
    chk("waw_stall_count", 128'(stall_count), 128'(5));
    step(1, 9, 0, 10, 0, 32'h302, 32'h999, 0, 0, 0, 0, 1, a);
    chk("waw_still_busy", 128'(a), 128'(0));
    step(1, 9, 0, 10, 0, 32'h302, 32'h999, 0, 1, 9, 32'h999, 1, a);
    chk("waw_second_wb_accept", 128'(a), 128'(1));
    chk("waw2_stall_count", 128'(stall_count), 128'(6));

    step(1, 5, 0, 0, 0, 32'h400, 32'h11, 0, 0, 0, 0, 1, a);
    chk("bp_first_accept", 128'(a), 128'(1));
    for (int k = 0; k < 4; k++) begin
      step(1, 6, 0, 0, 0, 32'h401, 32'h22, 0, 0, 0, 0, 0, a);
      chk($sformatf("bp_blocked%0d", k), 128'(a), 128'(0));
      chk($sformatf("bp_hold%0d", k), 128'({out_valid, out_op1, out_tag}), 128'({1'b1, 32'h11, 32'h400}));
      chk($sformatf("bp_stall_count%0d", k), 128'(stall_count), 128'(6));
    end
    step(1, 6, 0, 0, 0, 32'h401, 32'h22, 0, 0, 0, 0, 1, a);
    chk("bp_release_accept", 128'(a), 128'(1));

    step(1, 0, 0, 3, 1, 32'h500, 0, 0, 0, 0, 0, 1, a);
    chk("busy3_accept", 128'(a), 128'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    rst = 1'b1; in_valid = 1'b0; wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("rst2_out_valid", 128'(out_valid), 128'(0));
    chk("rst2_stall_count", 128'(stall_count), 128'(0));
    step(1, 3, 0, 11, 0, 32'h600, 32'hA000_0003, 0, 1, 0, 32'h5555, 1, a);
    chk("post_rst_x3_accept", 128'(a), 128'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    chk("queue_drained", 128'(q.size()), 128'(0));
    chk("final_stall_count", 128'(stall_count), 128'(0));

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
